// File: rtl/act_lut_interp_pipe.sv
// act_lut_interp_pipe: pipelined piecewise-linear activation.
// A 2^ADDR_W-entry runtime-writable table gives the segment end points and a
// linear interpolation between neighbouring entries gives the result.
// Three register stages (S1 table read, S2 multiply, S3 add), valid/ready
// handshake, global stall when the output is blocked.
// Optional build macro ACT_ROUND_EN: round-half-up interpolation instead of floor.
// Parameters must satisfy 2 <= ADDR_W < DATA_W.
`timescale 1ns/1ps
module act_lut_interp_pipe #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_z,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_a,
  input  logic              lut_we,
  input  logic [ADDR_W-1:0] lut_waddr,
  input  logic [DATA_W-1:0] lut_wdata
);

  localparam int FRAC_W = DATA_W - ADDR_W;
  localparam int DEPTH  = 1 << ADDR_W;
  // Product width: (DATA_W+1)-bit signed delta times FRAC_W-bit unsigned remainder.
  localparam int PROD_W = DATA_W + FRAC_W + 1;
  // Most positive segment index: its upper neighbour would wrap to the most
  // negative entry, so that segment is held flat instead.
  localparam logic [ADDR_W-1:0] TOP_ADDR = ADDR_W'((1 << (ADDR_W - 1)) - 1);
`ifdef ACT_ROUND_EN
  localparam logic [PROD_W-1:0] HALF_LSB = PROD_W'(1) << (FRAC_W - 1);
`endif

  // Table storage (register file so it can be restored to the identity ramp on reset).
  logic [DATA_W-1:0] lut_q [DEPTH];

  // Global advance enable: everything moves only when the output slot is free.
  logic en;

  // S1 (input split and table read) signals.
  logic [ADDR_W-1:0] addr_d;
  logic [ADDR_W-1:0] nidx_d;
  logic [FRAC_W-1:0] rem_d;
  logic [DATA_W-1:0] base_d;
  logic [DATA_W-1:0] next_d;
  logic              v1_q;
  logic [DATA_W-1:0] base1_q;
  logic [DATA_W-1:0] next1_q;
  logic [FRAC_W-1:0] rem1_q;

  // S2 (slope times remainder) signals.
  logic [DATA_W:0]   delta_d;
  logic [PROD_W-1:0] delta_x;
  logic [PROD_W-1:0] rem_x;
  logic [PROD_W-1:0] prod_d;
  logic              v2_q;
  logic [DATA_W-1:0] base2_q;
  logic [PROD_W-1:0] prod2_q;

  // S3 (final add) signals.
  logic [PROD_W-1:0] prod_adj_d;
  logic [DATA_W-1:0] a_d;
  logic              v3_q;
  logic [DATA_W-1:0] a3_q;

  assign en        = !v3_q || out_ready;
  assign in_ready  = en;
  assign out_valid = v3_q;
  assign out_a     = a3_q;

  // Table: identity ramp on reset (entry k = k in the integer bits), writes land at
  // the clock edge regardless of stalls; a same-cycle S1 read sees the old value.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int k = 0; k < DEPTH; k++) begin
        lut_q[k] <= {ADDR_W'(k), {FRAC_W{1'b0}}};
      end
    end else if (lut_we) begin
      lut_q[lut_waddr] <= lut_wdata;
    end
  end

  // S1 combinational: split z into segment index and fraction, pick both end points.
  always_comb begin
    addr_d = in_z[DATA_W-1:FRAC_W];
    rem_d  = in_z[FRAC_W-1:0];
    nidx_d = (addr_d == TOP_ADDR) ? addr_d : addr_d + ADDR_W'(1);
    base_d = lut_q[addr_d];
    next_d = lut_q[nidx_d];
  end

  // S1 register: captured end points and fraction of the accepted sample.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      v1_q    <= 1'b0;
      base1_q <= '0;
      next1_q <= '0;
      rem1_q  <= '0;
    end else if (en) begin
      v1_q    <= in_valid;
      base1_q <= base_d;
      next1_q <= next_d;
      rem1_q  <= rem_d;
    end
  end

  // S2 combinational: signed slope across the segment scaled by the fraction.
  always_comb begin
    delta_d = {next1_q[DATA_W-1], next1_q} - {base1_q[DATA_W-1], base1_q};
    delta_x = {{(PROD_W - DATA_W - 1){delta_d[DATA_W]}}, delta_d};
    rem_x   = {{(PROD_W - FRAC_W){1'b0}}, rem1_q};
    prod_d  = delta_x * rem_x;
  end

  // S2 register: base passes alongside the product.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      v2_q    <= 1'b0;
      base2_q <= '0;
      prod2_q <= '0;
    end else if (en) begin
      v2_q    <= v1_q;
      base2_q <= base1_q;
      prod2_q <= prod_d;
    end
  end

  // S3 combinational: scale product back to table units and add to base.
  // The result stays between the two end points, so truncation cannot overflow.
  always_comb begin
`ifdef ACT_ROUND_EN
    prod_adj_d = prod2_q + HALF_LSB;
`else
    prod_adj_d = prod2_q;
`endif
    a_d = base2_q + DATA_W'($signed(prod_adj_d) >>> FRAC_W);
  end

  // S3 register: output slot, held while the consumer stalls.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      v3_q <= 1'b0;
      a3_q <= '0;
    end else if (en) begin
      v3_q <= v2_q;
      a3_q <= a_d;
    end
  end

endmodule

// File: tb/tb_act_lut_interp_pipe.sv
// Directed bench for act_lut_interp_pipe (DATA_W=8, ADDR_W=4).
// Results are collected by a monitor into a queue and compared against
// hand-computed values; latency and stall behaviour are checked cycle by cycle.
`timescale 1ns/1ps
module tb_act_lut_interp_pipe;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_z;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_a;
  logic       lut_we;
  logic [3:0] lut_waddr;
  logic [7:0] lut_wdata;

  int err_cnt = 0;
  int chk_cnt = 0;
  logic [7:0] res_q[$];

`ifdef ACT_ROUND_EN
  localparam logic [7:0] EXP_T4_OLD = 8'h12;
  localparam logic [7:0] EXP_T4_NEW = 8'h32;
`else
  localparam logic [7:0] EXP_T4_OLD = 8'h11;
  localparam logic [7:0] EXP_T4_NEW = 8'h31;
`endif

  always #5 clk = ~clk;

  act_lut_interp_pipe #(.DATA_W(8), .ADDR_W(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_z      (in_z),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_a     (out_a),
    .lut_we    (lut_we),
    .lut_waddr (lut_waddr),
    .lut_wdata (lut_wdata)
  );

  // Inputs change only just after rising edges, so the falling edge sees the
  // handshake exactly as the next rising edge will.
  always @(negedge clk) begin
    if (rst && out_valid && out_ready) begin
      res_q.push_back(out_a);
      $display("out_a=%02h", out_a);
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    chk_cnt++;
    if (obs !== exp_v) begin
      err_cnt++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp_v);
    end else begin
      $display("ok   %s: %0h", tag, obs);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present z and hold it until accepted; in_valid is left high for back-to-back use.
  task automatic send(input logic [7:0] z);
    in_valid = 1'b1;
    in_z     = z;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (in_ready) break;
    end
    if (!in_ready) check_eq("send_accept", 32'(in_ready), 32'd1);
    step();
  endtask

  task automatic lut_write(input logic [3:0] addr, input logic [7:0] data);
    lut_we    = 1'b1;
    lut_waddr = addr;
    lut_wdata = data;
    step();
    lut_we    = 1'b0;
  endtask

  task automatic wait_results(input string tag, input int n);
    for (int i = 0; i < 100 && res_q.size() < n; i++) step();
    repeat (3) step();
    check_eq(tag, 32'(res_q.size()), 32'(n));
  endtask

  task automatic check_next(input string tag, input logic [7:0] exp_v);
    logic [7:0] v;
    v = 'x;
    if (res_q.size() > 0) v = res_q.pop_front();
    check_eq(tag, {24'h0, v}, {24'h0, exp_v});
  endtask

  initial begin
    rst       = 1'b0;
    in_valid  = 1'b0;
    in_z      = '0;
    out_ready = 1'b1;
    lut_we    = 1'b0;
    lut_waddr = '0;
    lut_wdata = '0;
    repeat (2) @(posedge clk);
    #1;
    check_eq("rst_out_valid", 32'(out_valid), 32'd0);
    check_eq("rst_out_a", 32'(out_a), 32'd0);
    check_eq("rst_in_ready", 32'(in_ready), 32'd1);
    rst = 1'b1;
    step();

    // 1: identity table, back-to-back, 3-cycle latency.
    res_q.delete();
    in_valid = 1'b1;
    in_z     = 8'h35;
    step();
    in_z     = 8'hC7;
    step();
    in_valid = 1'b0;
    check_eq("t1_not_yet", 32'(out_valid), 32'd0);
    step();
    check_eq("t1_v0", 32'(out_valid), 32'd1);
    check_eq("t1_a0", 32'(out_a), 32'h35);
    step();
    check_eq("t1_v1", 32'(out_valid), 32'd1);
    check_eq("t1_a1", 32'(out_a), 32'hC7);
    step();
    check_eq("t1_done", 32'(out_valid), 32'd0);
    res_q.delete();

    // 2: flat top segment and natural wrap from all-ones to entry 0.
    send(8'h7A);
    send(8'hFF);
    in_valid = 1'b0;
    wait_results("t2_count", 2);
    check_next("t2_clamp", 8'h70);
    check_next("t2_wrap", 8'hFF);

    // 3: programmed table.
    lut_write(4'd2, 8'h10);
    lut_write(4'd3, 8'h30);
    send(8'h28);
    in_valid = 1'b0;
    wait_results("t3_count", 1);
    check_next("t3_prog", 8'h20);

    // 4: interpolation rounding.
    lut_write(4'd3, 8'h13);
    send(8'h28);
    in_valid = 1'b0;
    wait_results("t4_count", 1);
    check_next("t4_round", EXP_T4_OLD);

    // Same-cycle write reads the old entry, the next sample sees the new one,
    // and a write while that sample is in S2 does not disturb it.
    lut_we    = 1'b1;
    lut_waddr = 4'd2;
    lut_wdata = 8'h50;
    in_valid  = 1'b1;
    in_z      = 8'h28;
    step();
    lut_we    = 1'b0;
    step();
    in_valid  = 1'b0;
    lut_we    = 1'b1;
    lut_wdata = 8'h20;
    step();
    lut_we    = 1'b0;
    wait_results("t4w_count", 2);
    check_next("t4w_old", EXP_T4_OLD);
    check_next("t4w_new", EXP_T4_NEW);

    // 5: backpressure with a 6-sample stream (LUT[1], LUT[2] are identity again).
    fork
      begin
        for (int i = 0; i < 6; i++) send(8'h10 + 8'(i));
        in_valid = 1'b0;
      end
      begin
        out_ready = 1'b0;
        repeat (3) step();
        check_eq("t5_full_v", 32'(out_valid), 32'd1);
        check_eq("t5_full_a", 32'(out_a), 32'h10);
        check_eq("t5_full_rdy", 32'(in_ready), 32'd0);
        repeat (2) step();
        check_eq("t5_hold_a", 32'(out_a), 32'h10);
        check_eq("t5_hold_rdy", 32'(in_ready), 32'd0);
        out_ready = 1'b1;
      end
    join
    wait_results("t5_count", 6);
    for (int i = 0; i < 6; i++) check_next($sformatf("t5_seq%0d", i), 8'h10 + 8'(i));

    // 6: reset mid-flight flushes the pipe and restores the identity table.
    send(8'h30);
    send(8'h40);
    in_valid  = 1'b0;
    lut_we    = 1'b1;
    lut_waddr = 4'd2;
    lut_wdata = 8'h77;
    step();
    lut_we    = 1'b0;
    #2;
    rst = 1'b0;
    #1;
    check_eq("t6_flush_v", 32'(out_valid), 32'd0);
    check_eq("t6_flush_a", 32'(out_a), 32'd0);
    step();
    rst = 1'b1;
    res_q.delete();
    repeat (4) step();
    check_eq("t6_no_output", 32'(res_q.size()), 32'd0);
    send(8'h28);
    in_valid = 1'b0;
    wait_results("t6_count", 1);
    check_next("t6_identity", 8'h28);

    $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
    $finish;
  end

endmodule
